// File: rtl/shift_load_sequencer_if.sv
// Producer-side word handshake for shift_load_sequencer.
// Carries DIN/FILL with DIN_VALID/DIN_READY.
// Ports (master = producer, slave = sequencer):
//   DIN, DIN_VALID, FILL : producer -> sequencer
//   DIN_READY            : sequencer -> producer
interface shift_load_sequencer_if #(
    parameter int LENGTH = 4
);
    logic [LENGTH-1:0] DIN;
    logic              DIN_VALID;
    logic              DIN_READY;
    logic              FILL;

    modport master (
        output DIN,
        output DIN_VALID,
        output FILL,
        input  DIN_READY
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        input  FILL,
        output DIN_READY
    );
endinterface

// File: rtl/shift_load_sequencer.sv
// Control stage for a 4-bit parallel-load / serial-shift register
// (J-K serial in, active-low PE). Loads a word, shifts SHIFTS times
// with a captured fill bit, pulses DONE, and otherwise holds the
// register by reloading its own Q.
// Ports: CP clock, MR sync active-low reset, din_bus word handshake,
//   Q register feedback, P/PE/J/K register drive, BUSY, DONE.
// Optional macro SHIFT_LOAD_SEQUENCER_ROTATE_EN: serial bit taken
//   from Q3 so the register rotates; FILL is then ignored.
module shift_load_sequencer #(
    parameter int LENGTH = 4,
    parameter int SHIFTS = 4
) (
    input  logic                  CP,
    input  logic                  MR,
    shift_load_sequencer_if.slave din_bus,
    input  logic [LENGTH-1:0]     Q,
    output logic [LENGTH-1:0]     P,
    output logic                  PE,
    output logic                  J,
    output logic                  K,
    output logic                  BUSY,
    output logic                  DONE
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(SHIFTS - 1);

    state_t            state;
    logic [LENGTH-1:0] data_reg;
    logic              fill_reg;
    logic [7:0]        cnt;
    logic              ser;

    always_ff @(posedge CP) begin
        if (!MR) begin
            state    <= ST_IDLE;
            data_reg <= '0;
            fill_reg <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (din_bus.DIN_VALID) begin
                        data_reg <= din_bus.DIN;
                        fill_reg <= din_bus.FILL;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SHIFT_LOAD_SEQUENCER_ROTATE_EN
    // Feed Q3 back into Q0 so the word rotates.
    assign ser = Q[LENGTH-1];
`else
    assign ser = fill_reg;
`endif

    // Defaults hold the register (PE low, P=Q); this is also the
    // reset behaviour since MR gates every other state.
    always_comb begin
        P                 = Q;
        PE                = 1'b0;
        J                 = 1'b0;
        K                 = 1'b0;
        BUSY              = 1'b0;
        DONE              = 1'b0;
        din_bus.DIN_READY = 1'b0;
        if (MR) begin
            case (state)
                ST_IDLE: din_bus.DIN_READY = 1'b1;
                ST_LOAD: begin
                    P    = data_reg;
                    BUSY = 1'b1;
                end
                ST_SHIFT: begin
                    P    = data_reg;
                    PE   = 1'b1;
                    J    = ser;
                    K    = ser;
                    BUSY = 1'b1;
                end
                ST_DONE: DONE = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
